apb_master: RTL and testbench

//  APB4 requester (initiator): the other end of the dpmem APB completer.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_master_timeout_cnt.sv | 22 ++
 rtl/apb_master.sv | 101 ++++++++++
 tb/tb_apb_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and defaults for the APB4 requester.
package apb_pkg;
    localparam int APB_ADDR_WIDTH      = 32;
    localparam int APB_DATA_WIDTH      = 32;
    localparam int APB_STRB_WIDTH      = APB_DATA_WIDTH / 8;
    localparam int APB_TIMEOUT_DEFAULT = 16;
    typedef logic [APB_ADDR_WIDTH-1:0] addr_t;
    typedef logic [APB_DATA_WIDTH-1:0] data_t;
    typedef logic [APB_STRB_WIDTH-1:0] strb_t;
    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_fsm_enum;
    typedef struct packed {
        addr_t addr;
        logic  write;
        data_t wdata;
        strb_t strb;
    } apb_cmd_t;
endpackage

// File: rtl/apb_master_timeout_cnt.sv
// apb_timeout_cnt: saturating PREADY-wait counter; o_expire flags the increment that reaches TIMEOUT.
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_count;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && r_count != CW'(TIMEOUT))
            r_count <= r_count + CW'(1);
    end
    assign o_expire = i_inc && (r_count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master.sv
// apb_master: APB4 requester with valid/ready command port, one-cycle response pulse
// and a PREADY watchdog.
import apb_pkg::*;
module apb_master #(
    parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
    parameter int DATA_WIDTH = APB_DATA_WIDTH,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic                  cmd_write,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0] cmd_strb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_slverr,
    output logic                  rsp_timeout,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic [STRB_WIDTH-1:0] PSTRB,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    apb_fsm_enum r_state, w_next;
    apb_cmd_t    r_cmd;
    logic        r_rsp_valid, r_rsp_slverr, r_rsp_timeout;
    data_t       r_rsp_rdata;
    logic        w_done, w_accept, w_expire;

    generate
        if (TIMEOUT > 0) begin : g_wdog
            apb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
                .i_clk    (PCLK),
                .i_rst    (PRESET),
                .i_clr    (r_state == APB_SETUP),
                .i_inc    (r_state == APB_ACCESS && !PREADY),
                .o_expire (w_expire)
            );
        end else begin : g_nowdog
            assign w_expire = 1'b0;
        end
    endgenerate

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)
            r_state <= APB_IDLE;
        else
            r_state <= w_next;
    end

    // A completing ACCESS cycle doubles as an accept slot so back-to-back transfers skip IDLE.
    always_comb begin
        w_done    = (r_state == APB_ACCESS) && PREADY;
        cmd_ready = !PRESET && ((r_state == APB_IDLE) || w_done);
        w_accept  = cmd_valid && cmd_ready;
        w_next    = w_accept                 ? APB_SETUP  :
                    (r_state == APB_SETUP)   ? APB_ACCESS :
                    (w_done || w_expire)     ? APB_IDLE   : r_state;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_cmd         <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_slverr  <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd.addr  <= addr_t'(cmd_addr);
                r_cmd.write <= cmd_write;
                r_cmd.strb  <= cmd_write ? strb_t'(cmd_strb) : '0;
                if (cmd_write)
                    r_cmd.wdata <= data_t'(cmd_wdata);
            end
            r_rsp_valid   <= w_done || w_expire;
            r_rsp_rdata   <= (w_done && !r_cmd.write) ? data_t'(PRDATA) : '0;
            r_rsp_slverr  <= w_done ? PSLVERR : w_expire;
            r_rsp_timeout <= w_expire;
        end
    end

    assign PSEL        = (r_state != APB_IDLE);
    assign PENABLE     = (r_state == APB_ACCESS);
    assign PADDR       = r_cmd.addr[ADDR_WIDTH-1:0];
    assign PWRITE      = r_cmd.write;
    assign PWDATA      = r_cmd.wdata[DATA_WIDTH-1:0];
    assign PSTRB       = r_cmd.strb[STRB_WIDTH-1:0];
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata[DATA_WIDTH-1:0];
    assign rsp_slverr  = r_rsp_slverr;
    assign rsp_timeout = r_rsp_timeout;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table vectors, hand sequences and random transfers against a transfer-level model.
module tb_apb_master;
    localparam int TIMEOUT = 16;

    logic        PCLK = 1'b0, PRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0, PRDATA = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid, rsp_slverr, rsp_timeout;
    logic [31:0] rsp_rdata, PADDR, PWDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY = 1'b0, PSLVERR = 1'b0;
    logic [3:0]  PSTRB;

    int n_chk = 0, n_fail = 0;
    logic [31:0] last_wd = '0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          wt;
        logic [31:0] prdata;
        logic        err;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_to;
    } vec_t;

    vec_t tbl[7];

    apb_master #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .rsp_timeout(rsp_timeout), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One transfer, stepped cycle by cycle from the accept edge; phases come from the latency rules.
    task automatic do_xfer(input vec_t v);
        bit to_exp;
        int acc, lat;
        logic [31:0] e_wd;
        to_exp = (v.wt >= TIMEOUT);
        acc    = to_exp ? TIMEOUT : v.wt + 1;
        lat    = 2 + acc;
        e_wd   = v.wr ? v.wdata : last_wd;
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr;
        cmd_wdata = v.wdata; cmd_strb = v.strb;
        #1 check("idle_ready", cmd_ready, 1);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge PCLK);
            if (k == 1) cmd_valid = 1'b0;
            check("phase", {PSEL, PENABLE, rsp_valid},
                  k == 1 ? 3'b100 : k < lat ? 3'b110 : k == lat ? 3'b001 : 3'b000);
            if (k < lat)
                check("bus", {PADDR, PWRITE, PSTRB}, {v.addr, v.wr, v.wr ? v.strb : 4'h0});
            if (k == 1) check("pwdata", PWDATA, e_wd);
            if (k >= 2 && k < lat) begin
                PREADY  = (k - 2 == v.wt);
                PRDATA  = PREADY ? v.prdata : $urandom;
                PSLVERR = PREADY ? v.err : 1'($urandom_range(0, 1));
                if (PREADY) #1 check("access_ready", cmd_ready, 1);
            end
            if (k == lat) begin
                PREADY = 1'b0;
                check("rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, {v.e_rd, v.e_err, v.e_to});
            end
        end
        if (v.wr) last_wd = v.wdata;
    endtask

    initial begin
        tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h10, 32'h0,        4'hF, 3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 32'h14, 32'h0,        4'h0, 0,  32'h0000CAFE, 1'b1, 32'h0000CAFE, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 32'h20, 32'h01020304, 4'h6, 2,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'h30, 32'h0,        4'h0, 16, 32'h12345678, 1'b0, 32'h0,        1'b1, 1'b1};
        tbl[5] = '{1'b0, 32'h34, 32'h0,        4'h0, 15, 32'h00005A5A, 1'b0, 32'h00005A5A, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 32'h40, 32'h11223344, 4'h5, 20, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1};

        #1;
        check("rst_ready", cmd_ready, 0);
        check("rst_bus", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB}, '0);
        check("rst_rsp", {rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout}, '0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;

        foreach (tbl[i]) do_xfer(tbl[i]);

        // Back-to-back: write 0x4 then read 0x8 with cmd_valid held across the accept.
        @(negedge PCLK);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4; cmd_wdata = 32'hA5A5A5A5; cmd_strb = 4'h3;
        @(negedge PCLK);
        check("b2b_setup_a", {PSEL, PENABLE, PADDR}, {2'b10, 32'h4});
        cmd_write = 1'b0; cmd_addr = 32'h8;
        #1 check("b2b_setup_ready", cmd_ready, 0);
        @(negedge PCLK);
        check("b2b_access_a", {PSEL, PENABLE, PADDR}, {2'b11, 32'h4});
        PREADY = 1'b1; PSLVERR = 1'b0;
        #1 check("b2b_ready", cmd_ready, 1);
        @(negedge PCLK);
        check("b2b_setup_b", {PSEL, PENABLE, rsp_valid}, 3'b101);
        check("b2b_bus_b", {PADDR, PWRITE, PSTRB, PWDATA}, {32'h8, 1'b0, 4'h0, 32'hA5A5A5A5});
        check("b2b_rsp_a", {rsp_rdata, rsp_slverr, rsp_timeout}, '0);
        PREADY = 1'b0; cmd_valid = 1'b0;
        @(negedge PCLK);
        check("b2b_access_b", {PSEL, PENABLE, rsp_valid}, 3'b110);
        PREADY = 1'b1; PRDATA = 32'h13572468;
        @(negedge PCLK);
        check("b2b_rsp_b", {PSEL, rsp_valid, rsp_rdata, rsp_slverr}, {2'b01, 32'h13572468, 1'b0});
        PREADY = 1'b0;
        @(negedge PCLK);
        check("b2b_end", rsp_valid, 0);
        last_wd = 32'hA5A5A5A5;

        // Reset asserted in the middle of ACCESS.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        check("rst_mid_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESET = 1'b1;
        #1 check("rst_mid_drop", {PSEL, PENABLE, cmd_ready}, 3'b000);
        @(negedge PCLK);
        check("rst_mid_norsp", rsp_valid, 0);
        PRESET = 1'b0;
        @(negedge PCLK);
        check("rst_after", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0001);
        last_wd = '0;
        do_xfer('{1'b0, 32'h24, 32'h0, 4'h0, 1, 32'h0BADF00D, 1'b0, 32'h0BADF00D, 1'b0, 1'b0});

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            bit to_exp;
            v.wr     = 1'($urandom_range(0, 1));
            v.addr   = $urandom & 32'hFFFF_FFFC;
            v.wdata  = $urandom;
            v.strb   = 4'($urandom_range(0, 15));
            v.wt     = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT, TIMEOUT + 3)
                                                   : $urandom_range(0, 4);
            v.prdata = $urandom;
            v.err    = ($urandom_range(0, 4) == 0);
            to_exp   = (v.wt >= TIMEOUT);
            v.e_to   = to_exp;
            v.e_err  = to_exp | v.err;
            v.e_rd   = (to_exp || v.wr) ? 32'h0 : v.prdata;
            do_xfer(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
